// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side operand forwarding and stall/flush control.
// Forwarding is enabled by defining ID_EX_FORWARD_EN; otherwise stored operands pass straight through.
module id_ex_stage (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        STALL,
   input  logic        FLUSH,
   input  logic        ID_VALID,
   input  logic [31:0] ID_RS_DATA,
   input  logic [31:0] ID_RT_DATA,
   input  logic [31:0] ID_IMM,
   input  logic        ID_USE_IMM,
   input  logic [4:0]  ID_RS_ADDR,
   input  logic [4:0]  ID_RT_ADDR,
   input  logic [4:0]  ID_RD_ADDR,
   input  logic        ID_REG_WRITE,
   input  logic [4:0]  ID_S,
   input  logic [3:0]  ID_ALUCTR,
   input  logic [1:0]  ID_ALUMOVOP,
   input  logic        EXMEM_REG_WRITE,
   input  logic [4:0]  EXMEM_RD_ADDR,
   input  logic [31:0] EXMEM_RESULT,
   input  logic        MEMWB_REG_WRITE,
   input  logic [4:0]  MEMWB_RD_ADDR,
   input  logic [31:0] MEMWB_RESULT,
   output logic        EX_VALID,
   output logic [31:0] EX_DATA_IN1,
   output logic [31:0] EX_DATA_IN2,
   output logic [4:0]  EX_S,
   output logic [3:0]  EX_ALUCTR,
   output logic [1:0]  EX_ALUMOVOP,
   output logic [4:0]  EX_RD_ADDR,
   output logic        EX_REG_WRITE,
   output logic [31:0] EX_STORE_DATA
);

   logic        r_valid;
   logic [31:0] r_rs_data;
   logic [31:0] r_rt_data;
   logic [31:0] r_imm;
   logic        r_use_imm;
   logic [4:0]  r_rs_addr;
   logic [4:0]  r_rt_addr;
   logic [4:0]  r_rd_addr;
   logic        r_reg_write;
   logic [4:0]  r_s;
   logic [3:0]  r_aluctr;
   logic [1:0]  r_alumovop;

   logic [31:0] w_fwd_rs;
   logic [31:0] w_fwd_rt;

`ifdef ID_EX_FORWARD_EN
   // EX/MEM is the younger producer, so it wins over MEM/WB; $zero is never forwarded.
   function automatic logic [31:0] fwd_sel(input logic [4:0] addr, input logic [31:0] stored);
      logic [31:0] v;
      v = stored;
      if (EXMEM_REG_WRITE && (EXMEM_RD_ADDR != 5'd0) && (EXMEM_RD_ADDR == addr))
         v = EXMEM_RESULT;
      else if (MEMWB_REG_WRITE && (MEMWB_RD_ADDR != 5'd0) && (MEMWB_RD_ADDR == addr))
         v = MEMWB_RESULT;
      return v;
   endfunction

   always_comb begin
      w_fwd_rs = fwd_sel(r_rs_addr, r_rs_data);
      w_fwd_rt = fwd_sel(r_rt_addr, r_rt_data);
   end
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{EXMEM_REG_WRITE, EXMEM_RD_ADDR, EXMEM_RESULT,
                           MEMWB_REG_WRITE, MEMWB_RD_ADDR, MEMWB_RESULT,
                           r_rs_addr, r_rt_addr};

   always_comb begin
      w_fwd_rs = r_rs_data;
      w_fwd_rt = r_rt_data;
   end
`endif

   always_ff @(posedge CLK) begin
      if (!RST_N || FLUSH || (!STALL && !ID_VALID)) begin
         r_valid     <= 1'b0;
         r_rs_data   <= '0;
         r_rt_data   <= '0;
         r_imm       <= '0;
         r_use_imm   <= 1'b0;
         r_rs_addr   <= '0;
         r_rt_addr   <= '0;
         r_rd_addr   <= '0;
         r_reg_write <= 1'b0;
         r_s         <= '0;
         r_aluctr    <= '0;
         r_alumovop  <= '0;
      end else if (STALL) begin
         // Capture any forwarded value now so a producer retiring mid-stall is not lost.
         r_rs_data <= w_fwd_rs;
         r_rt_data <= w_fwd_rt;
      end else begin
         r_valid     <= 1'b1;
         r_rs_data   <= ID_RS_DATA;
         r_rt_data   <= ID_RT_DATA;
         r_imm       <= ID_IMM;
         r_use_imm   <= ID_USE_IMM;
         r_rs_addr   <= ID_RS_ADDR;
         r_rt_addr   <= ID_RT_ADDR;
         r_rd_addr   <= ID_RD_ADDR;
         r_reg_write <= ID_REG_WRITE;
         r_s         <= ID_S;
         r_aluctr    <= ID_ALUCTR;
         r_alumovop  <= ID_ALUMOVOP;
      end
   end

   assign EX_VALID      = r_valid;
   assign EX_DATA_IN1   = w_fwd_rs;
   assign EX_DATA_IN2   = r_use_imm ? r_imm : w_fwd_rt;
   assign EX_STORE_DATA = w_fwd_rt;
   assign EX_S          = r_s;
   assign EX_ALUCTR     = r_aluctr;
   assign EX_ALUMOVOP   = r_alumovop;
   assign EX_RD_ADDR    = r_rd_addr;
   assign EX_REG_WRITE  = r_valid & r_reg_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed cases then randomized traffic against a behavioural model.
// Model follows ID_EX_FORWARD_EN the same way the design does.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N, STALL, FLUSH, ID_VALID, ID_USE_IMM, ID_REG_WRITE;
   logic [31:0] ID_RS_DATA, ID_RT_DATA, ID_IMM;
   logic [4:0]  ID_RS_ADDR, ID_RT_ADDR, ID_RD_ADDR, ID_S;
   logic [3:0]  ID_ALUCTR;
   logic [1:0]  ID_ALUMOVOP;
   logic        EXMEM_REG_WRITE, MEMWB_REG_WRITE;
   logic [4:0]  EXMEM_RD_ADDR, MEMWB_RD_ADDR;
   logic [31:0] EXMEM_RESULT, MEMWB_RESULT;
   logic        EX_VALID, EX_REG_WRITE;
   logic [31:0] EX_DATA_IN1, EX_DATA_IN2, EX_STORE_DATA;
   logic [4:0]  EX_S, EX_RD_ADDR;
   logic [3:0]  EX_ALUCTR;
   logic [1:0]  EX_ALUMOVOP;

   int checks = 0;
   int errors = 0;

   always #5 CLK = ~CLK;

   id_ex_stage dut (
      .CLK(CLK), .RST_N(RST_N), .STALL(STALL), .FLUSH(FLUSH),
      .ID_VALID(ID_VALID), .ID_RS_DATA(ID_RS_DATA), .ID_RT_DATA(ID_RT_DATA),
      .ID_IMM(ID_IMM), .ID_USE_IMM(ID_USE_IMM),
      .ID_RS_ADDR(ID_RS_ADDR), .ID_RT_ADDR(ID_RT_ADDR), .ID_RD_ADDR(ID_RD_ADDR),
      .ID_REG_WRITE(ID_REG_WRITE), .ID_S(ID_S), .ID_ALUCTR(ID_ALUCTR), .ID_ALUMOVOP(ID_ALUMOVOP),
      .EXMEM_REG_WRITE(EXMEM_REG_WRITE), .EXMEM_RD_ADDR(EXMEM_RD_ADDR), .EXMEM_RESULT(EXMEM_RESULT),
      .MEMWB_REG_WRITE(MEMWB_REG_WRITE), .MEMWB_RD_ADDR(MEMWB_RD_ADDR), .MEMWB_RESULT(MEMWB_RESULT),
      .EX_VALID(EX_VALID), .EX_DATA_IN1(EX_DATA_IN1), .EX_DATA_IN2(EX_DATA_IN2),
      .EX_S(EX_S), .EX_ALUCTR(EX_ALUCTR), .EX_ALUMOVOP(EX_ALUMOVOP),
      .EX_RD_ADDR(EX_RD_ADDR), .EX_REG_WRITE(EX_REG_WRITE), .EX_STORE_DATA(EX_STORE_DATA)
   );

   // Instruction currently held in EX, as the model sees it.
   typedef struct packed {
      logic        v;
      logic [31:0] rs, rt, imm;
      logic        ui;
      logic [4:0]  rsa, rta, rda;
      logic        rw;
      logic [4:0]  s;
      logic [3:0]  ctr;
      logic [1:0]  mov;
   } instr_t;

   instr_t m;

   function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] stored);
      if (!FWD || addr == 5'd0) return stored;
      if (EXMEM_REG_WRITE && EXMEM_RD_ADDR == addr) return EXMEM_RESULT;
      if (MEMWB_REG_WRITE && MEMWB_RD_ADDR == addr) return MEMWB_RESULT;
      return stored;
   endfunction

   // Applies what the rising edge does to the held instruction, using inputs seen at that edge.
   task automatic model_edge();
      if (!RST_N || FLUSH) m = '0;
      else if (STALL) begin
         m.rs = fwd(m.rsa, m.rs);
         m.rt = fwd(m.rta, m.rt);
      end else if (!ID_VALID) m = '0;
      else begin
         m.v = 1'b1;          m.rs = ID_RS_DATA;   m.rt = ID_RT_DATA;
         m.imm = ID_IMM;      m.ui = ID_USE_IMM;   m.rsa = ID_RS_ADDR;
         m.rta = ID_RT_ADDR;  m.rda = ID_RD_ADDR;  m.rw = ID_REG_WRITE;
         m.s = ID_S;          m.ctr = ID_ALUCTR;   m.mov = ID_ALUMOVOP;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] rt_f;
      rt_f = fwd(m.rta, m.rt);
      chk({tag, ".valid"}, 32'(EX_VALID), 32'(m.v));
      chk({tag, ".in1"},   EX_DATA_IN1, fwd(m.rsa, m.rs));
      chk({tag, ".in2"},   EX_DATA_IN2, m.ui ? m.imm : rt_f);
      chk({tag, ".store"}, EX_STORE_DATA, rt_f);
      chk({tag, ".s"},     32'(EX_S), 32'(m.s));
      chk({tag, ".ctr"},   32'(EX_ALUCTR), 32'(m.ctr));
      chk({tag, ".mov"},   32'(EX_ALUMOVOP), 32'(m.mov));
      chk({tag, ".rd"},    32'(EX_RD_ADDR), 32'(m.rda));
      chk({tag, ".rw"},    32'(EX_REG_WRITE), 32'(m.v & m.rw));
   endtask

   task automatic clock();
      @(posedge CLK);
      model_edge();
      #1;
   endtask

   task automatic set_fwd(input logic ew, input logic [4:0] ea, input logic [31:0] er,
                          input logic mw, input logic [4:0] ma, input logic [31:0] mr);
      EXMEM_REG_WRITE = ew; EXMEM_RD_ADDR = ea; EXMEM_RESULT = er;
      MEMWB_REG_WRITE = mw; MEMWB_RD_ADDR = ma; MEMWB_RESULT = mr;
      #1;
   endtask

   task automatic set_id(input logic [4:0] rsa, input logic [31:0] rs, input logic [4:0] rta,
                         input logic [31:0] rt, input logic ui, input logic [31:0] imm);
      ID_VALID = 1'b1; ID_RS_ADDR = rsa; ID_RS_DATA = rs; ID_RT_ADDR = rta; ID_RT_DATA = rt;
      ID_USE_IMM = ui; ID_IMM = imm; ID_RD_ADDR = 5'd4; ID_REG_WRITE = 1'b1;
      ID_S = 5'd3; ID_ALUCTR = 4'd2; ID_ALUMOVOP = 2'd1;
   endtask

   initial begin
      m = '0;
      STALL = 1'b1; FLUSH = 1'b0; RST_N = 1'b0;
      set_id(5'd7, 32'h1234, 5'd6, 32'h5678, 1'b0, 32'h9);
      set_fwd(1'b1, 5'd7, 32'hFFFF, 1'b1, 5'd6, 32'hEEEE);
      // Reset wins over STALL; forwarding inactive when checked.
      clock();
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      check_all("reset");
      chk("reset_in1_zero", EX_DATA_IN1, 32'd0);

      // Basic ADD capture, one cycle latency.
      RST_N = 1'b1; STALL = 1'b0;
      set_id(5'd1, 32'd5, 5'd2, 32'd3, 1'b0, 32'h0);
      clock();
      check_all("basic");
      chk("basic_in1", EX_DATA_IN1, 32'd5);
      chk("basic_in2", EX_DATA_IN2, 32'd3);
      chk("basic_valid", 32'(EX_VALID), 32'd1);

      // EX/MEM has priority over MEM/WB.
      set_id(5'd8, 32'h100, 5'd2, 32'h3, 1'b0, 32'h0);
      clock();
      set_fwd(1'b1, 5'd8, 32'h11111111, 1'b1, 5'd8, 32'h22222222);
      check_all("prio");
      chk("prio_in1", EX_DATA_IN1, FWD ? 32'h11111111 : 32'h100);
      set_fwd(1'b0, 5'd8, 32'h11111111, 1'b1, 5'd8, 32'h22222222);
      chk("memwb_in1", EX_DATA_IN1, FWD ? 32'h22222222 : 32'h100);

      // $zero is never forwarded.
      set_id(5'd1, 32'h1, 5'd0, 32'h55, 1'b0, 32'h0);
      clock();
      set_fwd(1'b1, 5'd0, 32'hDEADBEEF, 1'b1, 5'd0, 32'hDEADBEEF);
      check_all("zero");
      chk("zero_in2", EX_DATA_IN2, 32'h55);

      // Forwarding source retires during a stall.
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      set_id(5'd9, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0);
      clock();
      set_fwd(1'b1, 5'd9, 32'hABCD0000, 1'b0, 5'd0, '0);
      STALL = 1'b1; ID_VALID = 1'b0;
      clock();
      set_fwd(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
      check_all("stall");
      chk("stall_in1", EX_DATA_IN1, FWD ? 32'hABCD0000 : 32'h1);
      chk("stall_valid", 32'(EX_VALID), 32'd1);

      // FLUSH beats STALL and a valid instruction.
      set_id(5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0);
      STALL = 1'b1; FLUSH = 1'b1;
      clock();
      check_all("flush");
      chk("flush_valid", 32'(EX_VALID), 32'd0);
      chk("flush_rw", 32'(EX_REG_WRITE), 32'd0);
      chk("flush_ctr", 32'(EX_ALUCTR), 32'd0);

      // Immediate operand, then reset mid-stream.
      STALL = 1'b0; FLUSH = 1'b0;
      set_id(5'd1, 32'h1, 5'd3, 32'h7, 1'b1, 32'hFFFFFFF0);
      clock();
      check_all("imm");
      chk("imm_in2", EX_DATA_IN2, 32'hFFFFFFF0);
      chk("imm_store", EX_STORE_DATA, 32'h7);
      RST_N = 1'b0;
      clock();
      check_all("midreset");
      chk("midreset_store", EX_STORE_DATA, 32'd0);
      RST_N = 1'b1;

      // Randomized traffic over a small register window to provoke hazards.
      for (int i = 0; i < 400; i++) begin
         RST_N = ($urandom_range(0, 39) != 0);
         STALL = ($urandom_range(0, 3) == 0);
         FLUSH = ($urandom_range(0, 9) == 0);
         ID_VALID = ($urandom_range(0, 4) != 0);
         ID_RS_DATA = $urandom; ID_RT_DATA = $urandom; ID_IMM = $urandom;
         ID_USE_IMM = 1'($urandom_range(0, 1));
         ID_RS_ADDR = 5'($urandom_range(0, 3));
         ID_RT_ADDR = 5'($urandom_range(0, 3));
         ID_RD_ADDR = 5'($urandom);
         ID_REG_WRITE = 1'($urandom_range(0, 1));
         ID_S = 5'($urandom); ID_ALUCTR = 4'($urandom); ID_ALUMOVOP = 2'($urandom);
         clock();
         set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
         check_all("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port RST_N  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports STALL in 1 hold stage contents; FLUSH in 1 insert bubble.
REQ-004 SHALL have ports ID_VALID in 1, ID_RS_DATA in 32, ID_RT_DATA in 32, ID_IMM in 32 (pre-extended), ID_USE_IMM in 1 (operand 2 = immediate).
REQ-005 SHALL have ports ID_RS_ADDR in 5, ID_RT_ADDR in 5, ID_RD_ADDR in 5, ID_REG_WRITE in 1, ID_S in 5 (shamt), ID_ALUCTR in 4, ID_ALUMOVOP in 2.
REQ-006 SHALL have forwarding inputs EXMEM_REG_WRITE in 1, EXMEM_RD_ADDR in 5, EXMEM_RESULT in 32, MEMWB_REG_WRITE in 1, MEMWB_RD_ADDR in 5, MEMWB_RESULT in 32.
REQ-007 SHALL have outputs EX_VALID 1, EX_DATA_IN1 32, EX_DATA_IN2 32, EX_S 5, EX_ALUCTR 4, EX_ALUMOVOP 2, EX_RD_ADDR 5, EX_REG_WRITE 1, EX_STORE_DATA 32; EX_DATA_IN1/2, EX_S, EX_ALUCTR, EX_ALUMOVOP drive ALU DATA_IN1/2, S, ALUCtr, ALUMovOp directly.

Function
REQ-008 SHALL be one pipeline register stage: latency 1 cycle ID->EX when STALL=0, FLUSH=0.
REQ-009 SHALL latch per cycle: rs value, rt value, imm, use_imm, rs/rt/rd addresses, reg_write, S, ALUCtr, ALUMovOp, valid=ID_VALID.
REQ-010 SHALL, when ID_VALID=0 and not stalled, load a bubble: valid=0, reg_write=0, ALUCtr=0, ALUMovOp=0, S=0, addresses=0, data=0.
REQ-011 SHALL, on FLUSH=1, load a bubble (REQ-010) regardless of STALL or ID_VALID; FLUSH has priority over STALL.
REQ-012 SHALL, on STALL=1 and FLUSH=0, keep all control/address fields and EX_VALID unchanged.
REQ-013 SHALL, on STALL=1, re-latch stored rs/rt values with their forwarded values (REQ-015) so a forwarding source retiring during the stall is not lost.
REQ-014 SHALL, when valid=0, drive EX_REG_WRITE=0 irrespective of stored field.
REQ-015 Forwarded rs/rt value: EXMEM_RESULT if EXMEM_REG_WRITE=1, EXMEM_RD_ADDR!=0 and address matches; else MEMWB_RESULT if MEMWB_REG_WRITE=1, MEMWB_RD_ADDR!=0 and matches; else stored value. EX/MEM priority over MEM/WB.
REQ-016 SHALL never forward for register address 0; stored value passes through.
REQ-017 EX_DATA_IN1 SHALL = forwarded rs value (combinational from stage regs and forwarding inputs).
REQ-018 EX_DATA_IN2 SHALL = stored imm when use_imm=1, else forwarded rt value.
REQ-019 EX_STORE_DATA SHALL = forwarded rt value regardless of use_imm.
REQ-020 EX_S, EX_ALUCTR, EX_ALUMOVOP, EX_RD_ADDR SHALL be direct register outputs, no combinational path from ID_* inputs.
REQ-021 SHALL contain no combinational path from ID_* inputs to any output.

Reset
REQ-022 SHALL, when RST_N=0 at a rising edge, clear all state: every output 0 (EX_DATA_IN1/2, EX_STORE_DATA = 0 with forwarding sources inactive).
REQ-023 Reset SHALL override STALL and FLUSH; an in-flight instruction is discarded.
REQ-024 SHALL resume capture on the first edge with RST_N=1.

Configuration
REQ-025 Macro ID_EX_FORWARD_EN defined: forwarding per REQ-013/015/016 active.
REQ-026 Macro ID_EX_FORWARD_EN undefined: forwarding inputs present but ignored; outputs use stored rs/rt values; STALL re-latch is a plain hold.

Verification
REQ-027 Basic: rs=0x00000005, rt=0x00000003, ALUCtr=ADD, valid -> next cycle EX_DATA_IN1=5, EX_DATA_IN2=3, EX_VALID=1.
REQ-028 Forward priority: rs addr=8, EXMEM rd=8 result 0x11111111, MEMWB rd=8 result 0x22222222, both writes=1 -> EX_DATA_IN1=0x11111111; with ID_EX_FORWARD_EN undefined -> stored value.
REQ-029 $zero: rt addr=0, EXMEM rd=0 write=1 result 0xDEADBEEF, use_imm=0 -> EX_DATA_IN2 = stored rt value.
REQ-030 Stall retire: stage holds rs addr=9, EXMEM rd=9 result 0xABCD0000, STALL=1 one cycle, then EXMEM idle -> EX_DATA_IN1 stays 0xABCD0000.
REQ-031 STALL=1, FLUSH=1 same cycle, valid instr -> EX_VALID=0, EX_REG_WRITE=0, EX_ALUCTR=0.
REQ-032 Immediate: use_imm=1, imm=0xFFFFFFF0, rt value 0x7 -> EX_DATA_IN2=0xFFFFFFF0, EX_STORE_DATA=0x7; RST_N=0 mid-stream -> all outputs 0 next edge.
